// File: rtl/axil_rd_channel_mux.sv
// -----------------------------------------------------------------------------
// axil_rd_channel_mux
//
// Read-path datapath stage of the priority AXI-Lite interconnect. Sits directly
// downstream of the read priority arbiter: it presents the masters' AR valids
// as request_rd and consumes the arbiter's registered one-hot grant_rd. The
// granted master's AR beat is registered towards the single shared slave. The
// slave's R beat is then passed combinationally back to that master.
//
// The arbiter releases its grant on the same edge this block completes
// (s_axil_rvalid && m_axil_rready[idx]), so both FSMs stay in lockstep.
//
// Handshake rule for every channel: a beat transfers on a rising edge of aclk
// where valid and ready are both 1. Once valid is raised, it and its payload
// stay stable until that edge.
//
// Ports
//   aclk, aresetn      clock, asynchronous active-low reset
//   request_rd         to arbiter, copy of m_axil_arvalid
//   grant_rd           from arbiter, one-hot registered grant
//   m_axil_ar*         per-master AR channel (slice i = master i)
//   m_axil_r*          per-master R channel (slice i = master i)
//   s_axil_ar*         shared slave AR channel (address/prot/valid registered)
//   s_axil_r*          shared slave R channel
// -----------------------------------------------------------------------------
module axil_rd_channel_mux #(
  parameter int NUMBER_MASTER = 20,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  // arbiter side
  output logic [NUMBER_MASTER-1:0]         request_rd,
  input  logic [NUMBER_MASTER-1:0]         grant_rd,
  // master side AR
  input  logic [NUMBER_MASTER*ADDR_WIDTH-1:0] m_axil_araddr,
  input  logic [NUMBER_MASTER*3-1:0]       m_axil_arprot,
  input  logic [NUMBER_MASTER-1:0]         m_axil_arvalid,
  output logic [NUMBER_MASTER-1:0]         m_axil_arready,
  // master side R
  output logic [NUMBER_MASTER*DATA_WIDTH-1:0] m_axil_rdata,
  output logic [NUMBER_MASTER*2-1:0]       m_axil_rresp,
  output logic [NUMBER_MASTER-1:0]         m_axil_rvalid,
  input  logic [NUMBER_MASTER-1:0]         m_axil_rready,
  // slave side AR
  output logic [ADDR_WIDTH-1:0]            s_axil_araddr,
  output logic [2:0]                       s_axil_arprot,
  output logic                             s_axil_arvalid,
  input  logic                             s_axil_arready,
  // slave side R
  input  logic [DATA_WIDTH-1:0]            s_axil_rdata,
  input  logic [1:0]                       s_axil_rresp,
  input  logic                             s_axil_rvalid,
  output logic                             s_axil_rready
);

  localparam int IW = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_idx;
  logic [ADDR_WIDTH-1:0]   r_araddr;
  logic [2:0]              r_arprot;
  logic                    r_arvalid;

  logic [IW-1:0]           w_gidx;
  logic [NUMBER_MASTER-1:0] w_gsel;     // lowest set bit of grant_rd, one-hot
  logic [NUMBER_MASTER-1:0] w_idx_oh;   // r_idx decoded to one-hot
  logic [NUMBER_MASTER-1:0] w_rsel;     // R routing select, zero outside DATA
  logic [ADDR_WIDTH-1:0]   w_gaddr;
  logic [2:0]              w_gprot;
  logic                    w_accept;
  logic                    w_r_done;

  assign request_rd = m_axil_arvalid;

  // Lowest-index grant wins, so a multi-hot grant still selects one master.
  // Scanning downwards lets the last match (the lowest index) overwrite.
  always_comb begin
    w_gidx = '0;
    w_gsel = '0;
    for (int i = NUMBER_MASTER - 1; i >= 0; i--) begin
      if (grant_rd[i]) begin
        w_gidx    = IW'(i);
        w_gsel    = '0;
        w_gsel[i] = 1'b1;
      end
    end
  end

  // AND-OR mux of the granted master's address and prot.
  always_comb begin
    w_gaddr = '0;
    w_gprot = '0;
    for (int i = 0; i < NUMBER_MASTER; i++) begin
      w_gaddr = w_gaddr | (m_axil_araddr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{w_gsel[i]}});
      w_gprot = w_gprot | (m_axil_arprot[i*3 +: 3] & {3{w_gsel[i]}});
    end
  end

  always_comb begin
    w_idx_oh = '0;
    for (int i = 0; i < NUMBER_MASTER; i++) begin
      w_idx_oh[i] = (r_idx == IW'(i));
    end
  end

  // A grant without the matching arvalid is a protocol violation: no accept.
  assign w_accept = (r_state == ST_IDLE) && (|(w_gsel & m_axil_arvalid));
  assign w_rsel   = (r_state == ST_DATA) ? w_idx_oh : '0;

  assign m_axil_arready = w_accept ? w_gsel : '0;

  // R channel: zero-latency pass-through to the latched master only.
  always_comb begin
    m_axil_rvalid = '0;
    m_axil_rdata  = '0;
    m_axil_rresp  = '0;
    for (int i = 0; i < NUMBER_MASTER; i++) begin
      m_axil_rvalid[i]                        = w_rsel[i] & s_axil_rvalid;
      m_axil_rdata[i*DATA_WIDTH +: DATA_WIDTH] = w_rsel[i] ? s_axil_rdata : '0;
      m_axil_rresp[i*2 +: 2]                  = w_rsel[i] ? s_axil_rresp : 2'b00;
    end
  end

  assign s_axil_rready = |(w_rsel & m_axil_rready);
  assign w_r_done      = s_axil_rvalid & s_axil_rready;

  assign s_axil_araddr  = r_araddr;
  assign s_axil_arprot  = r_arprot;
  assign s_axil_arvalid = r_arvalid;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_araddr  <= '0;
      r_arprot  <= '0;
      r_arvalid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_idx     <= w_gidx;
            r_araddr  <= w_gaddr;
            r_arprot  <= w_gprot;
            r_arvalid <= 1'b1;
            r_state   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (s_axil_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_r_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_arvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_rd_channel_mux.sv
// -----------------------------------------------------------------------------
// tb_axil_rd_channel_mux
//
// Drives read transactions through axil_rd_channel_mux while playing the
// arbiter (registered one-hot grant, released on R completion), the masters
// and the slave. Expected slave AR beats are queued when a master issues its
// request and popped when the slave side presents them. Expected R routing is
// built from the transaction's own master/data/resp.
// -----------------------------------------------------------------------------
module tb_axil_rd_channel_mux;

  localparam int N  = 20;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = N * DW;

  // clock / reset
  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [N-1:0]    request_rd;
  logic [N-1:0]    grant_rd;
  logic [N*AW-1:0] m_axil_araddr;
  logic [N*3-1:0]  m_axil_arprot;
  logic [N-1:0]    m_axil_arvalid;
  logic [N-1:0]    m_axil_arready;
  logic [N*DW-1:0] m_axil_rdata;
  logic [N*2-1:0]  m_axil_rresp;
  logic [N-1:0]    m_axil_rvalid;
  logic [N-1:0]    m_axil_rready;
  logic [AW-1:0]   s_axil_araddr;
  logic [2:0]      s_axil_arprot;
  logic            s_axil_arvalid;
  logic            s_axil_arready;
  logic [DW-1:0]   s_axil_rdata;
  logic [1:0]      s_axil_rresp;
  logic            s_axil_rvalid;
  logic            s_axil_rready;

  axil_rd_channel_mux #(
    .NUMBER_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .request_rd(request_rd), .grant_rd(grant_rd),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready)
  );

  // scoreboard
  logic [AW+2:0] exp_q[$];   // {prot, addr} of expected slave AR beats
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    grant_rd       = '0;
    m_axil_arvalid = '0;
    m_axil_rready  = '0;
    s_axil_arready = 1'b0;
    s_axil_rvalid  = 1'b0;
    s_axil_rdata   = '0;
    s_axil_rresp   = 2'b00;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_arready"}, CW'(m_axil_arready), '0);
    chk({tag, "_rvalid"},  CW'(m_axil_rvalid), '0);
    chk({tag, "_rdata"},   CW'(m_axil_rdata), '0);
    chk({tag, "_rresp"},   CW'(m_axil_rresp), '0);
    chk({tag, "_rready"},  CW'(s_axil_rready), '0);
  endtask

  // One complete read by master m. others: extra requesters (higher index,
  // so they lose), gext: extra grant bits above m, spur: slave rvalid noise
  // during ADDR, gjunk: grant changes after acceptance.
  task automatic do_read(input int m, input logic [AW-1:0] addr, input logic [2:0] prot,
                         input int ar_dly, input int rr_dly,
                         input logic [DW-1:0] data, input logic [1:0] resp,
                         input logic [N-1:0] others, input logic [N-1:0] gext,
                         input bit spur, input bit gjunk);
    logic [N-1:0]    oh;
    logic [N*DW-1:0] e_data;
    logic [N*2-1:0]  e_resp;
    logic [AW+2:0]   beat;
    oh = '0;
    oh[m] = 1'b1;
    e_data = '0;
    e_data[m*DW +: DW] = data;
    e_resp = '0;
    e_resp[m*2 +: 2] = resp;

    // cycle 0: master request, no grant yet
    m_axil_araddr[m*AW +: AW] = addr;
    m_axil_arprot[m*3 +: 3]   = prot;
    m_axil_arvalid            = oh | others;
    exp_q.push_back({prot, addr});
    #1;
    chk("request_rd", CW'(request_rd), CW'(oh | others));
    chk("arready_c0", CW'(m_axil_arready), '0);
    tick();
    // cycle 1: registered grant arrives, arready pulses for master m only
    grant_rd = oh | gext;
    #1;
    chk("arready_c1", CW'(m_axil_arready), CW'(oh));
    tick();
    // cycle 2: beat on slave side
    m_axil_arvalid = others;
    if (gjunk) grant_rd = N'($urandom) | N'(1);
    #1;
    chk("arready_c2", CW'(m_axil_arready), '0);
    chk("s_arvalid_c2", CW'(s_axil_arvalid), CW'(1));
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", CW'(1), CW'(0));
    end else begin
      beat = exp_q.pop_front();
      chk("s_ar_beat", CW'({s_axil_arprot, s_axil_araddr}), CW'(beat));
    end
    for (int i = 0; i < ar_dly; i++) begin
      s_axil_rvalid = spur;
      s_axil_rdata  = $urandom;
      s_axil_rresp  = 2'($urandom);
      #1;
      chk("addr_rvalid", CW'(m_axil_rvalid), '0);
      chk("addr_rready", CW'(s_axil_rready), '0);
      chk("addr_hold", CW'({s_axil_arvalid, s_axil_arprot, s_axil_araddr}), CW'({1'b1, prot, addr}));
      tick();
    end
    s_axil_rvalid  = 1'b0;
    s_axil_arready = 1'b1;
    tick();
    s_axil_arready = 1'b0;
    // DATA: slave response, master stalls rr_dly cycles
    s_axil_rvalid = 1'b1;
    s_axil_rdata  = data;
    s_axil_rresp  = resp;
    for (int i = 0; i < rr_dly; i++) begin
      m_axil_rready = N'($urandom) & ~oh;
      #1;
      chk("data_arvalid", CW'(s_axil_arvalid), '0);
      chk("stall_rvalid", CW'(m_axil_rvalid), CW'(oh));
      chk("stall_rdata", CW'(m_axil_rdata), CW'(e_data));
      chk("stall_rready", CW'(s_axil_rready), '0);
      tick();
    end
    m_axil_rready = oh | (N'($urandom) & ~oh);
    #1;
    chk("r_rvalid", CW'(m_axil_rvalid), CW'(oh));
    chk("r_rdata", CW'(m_axil_rdata), CW'(e_data));
    chk("r_rresp", CW'(m_axil_rresp), CW'(e_resp));
    chk("r_rready", CW'(s_axil_rready), CW'(1));
    tick();
    // completion edge: arbiter releases, slave drops rvalid
    grant_rd      = '0;
    s_axil_rvalid = 1'b0;
    m_axil_rready = '0;
    #1;
    chk_quiet("done");
    chk("done_arvalid", CW'(s_axil_arvalid), '0);
  endtask

  initial begin
    logic [N-1:0] above;
    int m;
    idle_inputs();
    m_axil_araddr = '0;
    m_axil_arprot = '0;
    #12;
    chk("rst_s_ar", CW'({s_axil_arvalid, s_axil_arprot, s_axil_araddr}), '0);
    chk_quiet("rst");
    aresetn = 1'b1;
    tick();
    chk_quiet("idle");

    // directed cases
    do_read(3, 32'h0000_0040, 3'b010, 2, 0, 32'hDEAD_BEEF, 2'b00, '0, '0, 0, 0);
    m_axil_araddr[5*AW +: AW] = 32'h0000_5550;
    do_read(2, 32'h0000_2220, 3'b001, 1, 0, 32'h2222_0000, 2'b00, N'(1) << 5, '0, 0, 0);
    do_read(5, 32'h0000_5550, 3'b100, 0, 1, 32'h5555_0000, 2'b00, '0, '0, 0, 0);
    do_read(0, 32'h0000_0A00, 3'b000, 1, 4, 32'h0BAD_F00D, 2'b00, '0, '0, 0, 0);
    do_read(7, 32'h0000_0700, 3'b111, 0, 0, 32'h7777_7777, 2'b10, '0, '0, 0, 0);
    do_read(4, 32'h0000_0444, 3'b011, 3, 0, 32'h4444_4444, 2'b00, '0, N'(3) << 8, 1, 1);

    // spurious slave rvalid while idle
    s_axil_rvalid = 1'b1;
    s_axil_rdata  = 32'hFFFF_FFFF;
    s_axil_rresp  = 2'b11;
    m_axil_rready = '1;
    #1;
    chk_quiet("spur_idle");
    tick();
    idle_inputs();

    // grant without arvalid: no accept, stays idle
    grant_rd = N'(1) << 9;
    #1;
    chk("viol_arready", CW'(m_axil_arready), '0);
    tick();
    chk("viol_arvalid", CW'(s_axil_arvalid), '0);
    grant_rd = '0;

    // asynchronous reset in the middle of DATA
    m_axil_araddr[4*AW +: AW] = 32'h0000_4000;
    m_axil_arvalid = N'(1) << 4;
    tick();
    grant_rd = N'(1) << 4;
    tick();
    m_axil_arvalid = '0;
    s_axil_arready = 1'b1;
    tick();
    s_axil_arready = 1'b0;
    s_axil_rvalid  = 1'b1;
    s_axil_rdata   = 32'h1234_5678;
    m_axil_rready  = N'(1) << 4;
    #1;
    chk("pre_rst_rready", CW'(s_axil_rready), CW'(1));
    chk("pre_rst_rvalid", CW'(m_axil_rvalid), CW'(N'(1) << 4));
    #1;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_arvalid", CW'(s_axil_arvalid), '0);
    chk_quiet("mid_rst");
    idle_inputs();
    tick();
    chk("mid_rst_addr", CW'({s_axil_arprot, s_axil_araddr}), '0);
    aresetn = 1'b1;
    tick();
    do_read(1, 32'h0000_0100, 3'b000, 1, 1, 32'hC0FF_EE01, 2'b00, '0, '0, 0, 0);

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      m = $urandom_range(0, N - 1);
      above = '1;
      above = above << (m + 1);
      for (int k = 0; k < N; k++) m_axil_araddr[k*AW +: AW] = $urandom;
      do_read(m, $urandom, 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom, 2'($urandom), N'($urandom) & above, N'($urandom) & above,
              1'($urandom), 1'($urandom));
      m_axil_arvalid = '0;
      tick();
    end

    chk("exp_q_drained", CW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
